// File: rtl/viterbi_tb_ctrl.sv
// Sequencer for the K=4, 8-state Viterbi decoder: survivor writes, block traceback, serial output, tail flush.
// Optional build macro VTB_BEST_STATE_EN: normal tracebacks start from min_state instead of state 0.
module viterbi_tb_ctrl #(
    parameter int AW      = 5,
    parameter int TB_LEN  = 15,
    parameter int DEC_LEN = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          seqrdy,
    input  logic          sym_valid,
    output logic          sym_ready,
    output logic          acs_en,
    output logic          wen,
    output logic [AW-1:0] write_ptr,
    output logic          ten,
    output logic [AW-1:0] trace_ptr,
    output logic [2:0]    tb_state,
    input  logic          dec_bit,
    input  logic [2:0]    min_state,
    output logic          Dx,
    output logic          oen,
    output logic          busy
);
    localparam int CW = $clog2(TB_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        LOAD,
        TRACE,
        OUTPUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TB_LEN-1:0] tb_reg;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     pend_m1;
    logic [CW-1:0]     step;
    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     nout;
    logic              flush;
    logic [2:0]        load_state;

`ifdef VTB_BEST_STATE_EN
    assign load_state = min_state;
`else
    logic unused_min_state;
    assign load_state       = 3'b000;
    assign unused_min_state = ^min_state;
`endif

    assign sym_ready = (state == WRITE) && seqrdy;
    assign wen       = sym_valid && sym_ready;
    assign acs_en    = wen;
    assign ten       = (state == TRACE);
    assign busy      = (state != IDLE);
    assign pend_m1   = pend - CW'(1);
    assign nout      = flush ? pend : CW'(DEC_LEN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (seqrdy) state_nxt = WRITE;
            end
            WRITE: begin
                if (!seqrdy) begin
                    state_nxt = (pend != '0) ? LOAD : IDLE;
                end else if (wen && (pend == CW'(TB_LEN - 1))) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = TRACE;
            end
            TRACE: begin
                if (step == pend_m1) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                if (out_cnt == nout) state_nxt = flush ? IDLE : WRITE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_ptr <= '0;
            trace_ptr <= '0;
            tb_state  <= '0;
            tb_reg    <= '0;
            pend      <= '0;
            step      <= '0;
            out_cnt   <= '0;
            flush     <= 1'b0;
            Dx        <= 1'b0;
            oen       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pend  <= '0;
                    flush <= 1'b0;
                end
                WRITE: begin
                    if (!seqrdy) begin
                        flush <= (pend != '0);
                    end else if (wen) begin
                        write_ptr <= write_ptr + AW'(1);
                        pend      <= pend + CW'(1);
                    end
                end
                LOAD: begin
                    tb_state  <= flush ? 3'b000 : load_state;
                    trace_ptr <= write_ptr - AW'(1);
                    step      <= '0;
                end
                TRACE: begin
                    tb_state  <= {tb_state[1:0], dec_bit};
                    trace_ptr <= trace_ptr - AW'(1);
                    step      <= step + CW'(1);
                    if (step == pend_m1) begin
                        // Last traced bit is the oldest: route it straight to Dx and fold the
                        // shift-in with the first output shift so oen rises right after TRACE.
                        Dx      <= tb_state[2];
                        oen     <= 1'b1;
                        tb_reg  <= {1'b0, tb_reg[TB_LEN-2:0]};
                        out_cnt <= CW'(1);
                    end else begin
                        tb_reg <= {tb_reg[TB_LEN-2:0], tb_state[2]};
                    end
                end
                OUTPUT: begin
                    if (out_cnt == nout) begin
                        oen <= 1'b0;
                        if (flush) begin
                            flush <= 1'b0;
                            pend  <= '0;
                        end else begin
                            pend <= pend - nout;
                        end
                    end else begin
                        Dx      <= tb_reg[0];
                        tb_reg  <= tb_reg >> 1;
                        out_cnt <= out_cnt + CW'(1);
                    end
                end
                default: begin
                    oen <= 1'b0;
                end
            endcase
        end
    end

endmodule
